mem2uart_frame: RTL and testbench



---
 rtl/lpc_sniffer_pkg.sv | 25 ++
 rtl/mem2uart_frame.sv | 137 +++++++++++++
 tb/tb_mem2uart_frame.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpc_sniffer_pkg.sv
// rtl/lpc_sniffer_pkg.sv - shared LPC capture record layout and reader FSM encoding
package lpc_sniffer_pkg;

  localparam int REC_OFF_TYPE  = 0;
  localparam int REC_OFF_ADDR3 = 1;
  localparam int REC_OFF_ADDR2 = 2;
  localparam int REC_OFF_ADDR1 = 3;
  localparam int REC_OFF_ADDR0 = 4;
  localparam int REC_OFF_DATA  = 5;
  localparam int REC_BYTES     = 6;
  localparam int SLOT_BYTES    = 8;

  localparam int SLOT_W = 5;
  localparam int OFF_W  = 3;

  typedef enum logic [2:0] {
    M2U_IDLE  = 3'd0,
    M2U_SYNC  = 3'd1,
    M2U_FETCH = 3'd2,
    M2U_LOAD  = 3'd3,
    M2U_SEND  = 3'd4,
    M2U_GAP   = 3'd5
  } m2u_state_e;

endpackage

// File: rtl/mem2uart_frame.sv
// rtl/mem2uart_frame.sv - streams one captured 6-byte LPC record per slot from RAM to the UART
module mem2uart_frame
  import lpc_sniffer_pkg::*;
#(
  parameter bit          EMIT_SYNC    = 1'b1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          RECORD_BYTES = REC_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              slot_valid,
  input  logic [SLOT_W-1:0] read_slot,
  output logic [7:0]        ram_addr,
  output logic              ram_rd_en,
  input  logic [7:0]        ram_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              slot_done,
  output logic              busy
);

  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(RECORD_BYTES - 1);

  m2u_state_e        state, state_d;
  logic [SLOT_W-1:0] slot_reg, slot_reg_d;
  logic [OFF_W-1:0]  byte_idx, byte_idx_d;
  logic [OFF_W-1:0]  next_idx;
  logic [7:0]        ram_addr_d;
  logic              ram_rd_en_d;
  logic [7:0]        tx_data_d;
  logic              tx_valid_d;
  logic              slot_done_d;
  logic              busy_d;

  assign next_idx = byte_idx + 3'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= M2U_IDLE;
      slot_reg  <= '0;
      byte_idx  <= '0;
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      slot_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      slot_reg  <= slot_reg_d;
      byte_idx  <= byte_idx_d;
      ram_addr  <= ram_addr_d;
      ram_rd_en <= ram_rd_en_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      slot_done <= slot_done_d;
      busy      <= busy_d;
    end
  end

  // Outputs are computed one cycle ahead so the read strobe lines up with the FETCH state itself.
  always_comb begin
    state_d     = state;
    slot_reg_d  = slot_reg;
    byte_idx_d  = byte_idx;
    ram_addr_d  = ram_addr;
    ram_rd_en_d = 1'b0;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    slot_done_d = 1'b0;

    case (state)
      M2U_IDLE: begin
        if (slot_valid) begin
          slot_reg_d = read_slot;
          byte_idx_d = '0;
          if (EMIT_SYNC) begin
            tx_data_d  = SYNC_BYTE;
            tx_valid_d = 1'b1;
            state_d    = M2U_SYNC;
          end else begin
            ram_addr_d  = {read_slot, 3'd0};
            ram_rd_en_d = 1'b1;
            state_d     = M2U_FETCH;
          end
        end
      end

      M2U_SYNC: begin
        if (tx_ready) begin
          tx_valid_d  = 1'b0;
          ram_addr_d  = {slot_reg, byte_idx};
          ram_rd_en_d = 1'b1;
          state_d     = M2U_FETCH;
        end
      end

      M2U_FETCH: begin
        state_d = M2U_LOAD;
      end

      M2U_LOAD: begin
        tx_data_d  = ram_data;
        tx_valid_d = 1'b1;
        state_d    = M2U_SEND;
      end

      M2U_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_idx == LAST_IDX) begin
            slot_done_d = 1'b1;
            state_d     = M2U_GAP;
          end else begin
            byte_idx_d  = next_idx;
            ram_addr_d  = {slot_reg, next_idx};
            ram_rd_en_d = 1'b1;
            state_d     = M2U_FETCH;
          end
        end
      end

      // Lets the ringbuffer update slot_valid/read_slot before IDLE samples them again.
      M2U_GAP: begin
        state_d = M2U_IDLE;
      end

      default: begin
        state_d = M2U_IDLE;
      end
    endcase

    busy_d = (state_d != M2U_IDLE);
  end

endmodule

// File: tb/tb_mem2uart_frame.sv
// tb/tb_mem2uart_frame.sv - randomized self-checking bench for mem2uart_frame against a record-level model
module tb_mem2uart_frame;
  import lpc_sniffer_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       slot_valid [2];
  logic [4:0] read_slot  [2];
  logic [7:0] ram_addr   [2];
  logic       ram_rd_en  [2];
  logic [7:0] ram_data   [2];
  logic [7:0] tx_data    [2];
  logic       tx_valid   [2];
  logic       tx_ready   [2];
  logic       slot_done  [2];
  logic       busy       [2];

  logic [7:0] mem [256];
  int         rmode [2];
  int         scnt  [2];
  int         cyc = 0;

  int obs_tx[$];
  int obs_addr[$];
  int obs_done[$];
  int hold_viol = 0;
  int stall_seen = 0;
  logic       prev_stall [2];
  logic [7:0] prev_data  [2];

  int exp_tx[$];
  int exp_addr[$];
  int tx_ptr = 0, addr_ptr = 0, done_ptr = 0;
  int c0;
  int n_checks = 0, n_errors = 0;

  always #5 clock = ~clock;

  mem2uart_frame #(.EMIT_SYNC(1'b1), .SYNC_BYTE(8'hA5), .RECORD_BYTES(6)) u_sync (
    .clock(clock), .reset(reset),
    .slot_valid(slot_valid[0]), .read_slot(read_slot[0]),
    .ram_addr(ram_addr[0]), .ram_rd_en(ram_rd_en[0]), .ram_data(ram_data[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .slot_done(slot_done[0]), .busy(busy[0])
  );

  mem2uart_frame #(.EMIT_SYNC(1'b0), .SYNC_BYTE(8'hA5), .RECORD_BYTES(6)) u_nosync (
    .clock(clock), .reset(reset),
    .slot_valid(slot_valid[1]), .read_slot(read_slot[1]),
    .ram_addr(ram_addr[1]), .ram_rd_en(ram_rd_en[1]), .ram_data(ram_data[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .slot_done(slot_done[1]), .busy(busy[1])
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Capture RAM with one cycle of read latency, one read port per DUT.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      if (ram_rd_en[i]) ram_data[i] <= mem[ram_addr[i]];
  end

  // UART side: mode 0 always ready, mode 1 random, mode 2 five stall cycles per byte.
  initial begin
    for (int i = 0; i < 2; i++) begin
      tx_ready[i] = 1'b0;
      scnt[i] = 0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!tx_valid[i]) begin
          tx_ready[i] = (rmode[i] == 0);
          scnt[i] = 0;
        end else if (rmode[i] == 0) begin
          tx_ready[i] = 1'b1;
        end else if (rmode[i] == 1) begin
          tx_ready[i] = ($urandom_range(0, 2) == 0);
        end else if (scnt[i] < 5) begin
          tx_ready[i] = 1'b0;
          scnt[i] = scnt[i] + 1;
        end else begin
          tx_ready[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        prev_stall[i] <= 1'b0;
      end else begin
        if (ram_rd_en[i]) obs_addr.push_back(i * 256 + int'(ram_addr[i]));
        if (tx_valid[i] && tx_ready[i]) obs_tx.push_back(i * 256 + int'(tx_data[i]));
        if (slot_done[i]) obs_done.push_back(i * 1000000 + cyc);
        if (prev_stall[i] && (!tx_valid[i] || tx_data[i] != prev_data[i])) hold_viol <= hold_viol + 1;
        if (tx_valid[i] && !tx_ready[i]) stall_seen <= stall_seen + 1;
        prev_stall[i] <= tx_valid[i] && !tx_ready[i];
        prev_data[i]  <= tx_data[i];
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference record: optional sync byte, then offsets 0..5 of the slot as stored.
  task automatic push_rec(input int i, input logic [4:0] s);
    logic [7:0] a;
    if (i == 0) exp_tx.push_back(8'hA5);
    for (int k = 0; k < REC_BYTES; k++) begin
      a = {s, 3'(k)};
      exp_tx.push_back(i * 256 + int'(mem[a]));
      exp_addr.push_back(i * 256 + int'(a));
    end
  endtask

  task automatic start_slot(input int i, input logic [4:0] s);
    slot_valid[i] = 1'b1;
    read_slot[i]  = s;
    c0 = cyc;
    tick();
    slot_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int guard;
    guard = 0;
    while (!slot_done[i] && guard < 400) begin
      tick();
      guard++;
    end
    check_eq({tag, " slot_done seen"}, int'(slot_done[i]), 1);
    tick();
  endtask

  function automatic int done_cyc(input int k);
    if (done_ptr + k < obs_done.size()) return obs_done[done_ptr + k] % 1000000;
    return -1000;
  endfunction

  task automatic compare_stream(input string tag, input int n_done, input int lat);
    check_eq({tag, " tx count"}, obs_tx.size() - tx_ptr, exp_tx.size());
    foreach (exp_tx[k])
      if (tx_ptr + k < obs_tx.size()) check_eq({tag, " tx byte"}, obs_tx[tx_ptr + k], exp_tx[k]);
    check_eq({tag, " rd count"}, obs_addr.size() - addr_ptr, exp_addr.size());
    foreach (exp_addr[k])
      if (addr_ptr + k < obs_addr.size()) check_eq({tag, " ram_addr"}, obs_addr[addr_ptr + k], exp_addr[k]);
    check_eq({tag, " slot_done count"}, obs_done.size() - done_ptr, n_done);
    if (lat >= 0) check_eq({tag, " slot_done cycle"}, done_cyc(0) - c0, lat);
    check_eq({tag, " hold stable"}, hold_viol, 0);
    tx_ptr   = obs_tx.size();
    addr_ptr = obs_addr.size();
    done_ptr = obs_done.size();
    exp_tx.delete();
    exp_addr.delete();
  endtask

  task automatic check_zero(input int i, input string tag);
    check_eq({tag, " tx_valid"},  int'(tx_valid[i]),  0);
    check_eq({tag, " tx_data"},   int'(tx_data[i]),   0);
    check_eq({tag, " ram_rd_en"}, int'(ram_rd_en[i]), 0);
    check_eq({tag, " ram_addr"},  int'(ram_addr[i]),  0);
    check_eq({tag, " slot_done"}, int'(slot_done[i]), 0);
    check_eq({tag, " busy"},      int'(busy[i]),      0);
  endtask

  initial begin
    int guard, base, d0, d1, d2, inst, mode;
    logic [4:0] s;

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slot_valid[i] = 1'b0;
      read_slot[i]  = '0;
      rmode[i]      = 0;
    end
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    {mem[8'h18], mem[8'h19], mem[8'h1A], mem[8'h1B], mem[8'h1C], mem[8'h1D]} = 48'h0D_00_00_00_80_42;
    {mem[8'hF8], mem[8'hF9], mem[8'hFA], mem[8'hFB], mem[8'hFC], mem[8'hFD]} = 48'h02_FF_FF_00_60_55;

    repeat (3) tick();
    check_zero(0, "reset sync");
    check_zero(1, "reset nosync");
    reset = 1'b1;
    repeat (2) tick();

    // Slot 3, always ready: A5 then the record, slot_done 20 cycles after the IDLE sample.
    start_slot(0, 5'd3);
    push_rec(0, 5'd3);
    wait_done(0, "slot3");
    compare_stream("slot3", 1, 20);
    check_eq("slot3 idle after", int'(busy[0]), 0);

    // Same record with five stall cycles on every byte.
    rmode[0] = 2;
    base = stall_seen;
    start_slot(0, 5'd3);
    push_rec(0, 5'd3);
    wait_done(0, "stall");
    compare_stream("stall", 1, -1);
    check_eq("stall exercised", int'(stall_seen - base >= 35), 1);

    // Back-to-back slots 0,1,2 with slot_valid held high.
    rmode[0] = 0;
    slot_valid[0] = 1'b1;
    read_slot[0]  = 5'd0;
    c0 = cyc;
    for (int n = 0; n < 3; n++) begin
      push_rec(0, 5'(n));
      guard = 0;
      while (!slot_done[0] && guard < 400) begin
        tick();
        guard++;
      end
      check_eq("b2b slot_done seen", int'(slot_done[0]), 1);
      if (n < 2) read_slot[0] = 5'(n + 1);
      else slot_valid[0] = 1'b0;
      tick();
    end
    repeat (3) tick();
    d0 = done_cyc(0);
    d1 = done_cyc(1);
    d2 = done_cyc(2);
    check_eq("b2b first done", d0 - c0, 20);
    check_eq("b2b spacing 1", d1 - d0, 21);
    check_eq("b2b spacing 2", d2 - d1, 21);
    compare_stream("b2b", 3, -1);

    // Reset during SEND of offset 2 of slot 7: no slot_done, record restarts from the sync byte.
    rmode[0] = 2;
    start_slot(0, 5'd7);
    guard = 0;
    while (!((obs_tx.size() - tx_ptr) >= 3 && tx_valid[0]) && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("abort reached offset 2", int'(guard < 200), 1);
    #2 reset = 1'b0;
    #1 check_zero(0, "abort");
    tick();
    tick();
    reset = 1'b1;
    tick();
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(int'(mem[8'h38]));
    exp_tx.push_back(int'(mem[8'h39]));
    for (int k = 0; k < 3; k++) exp_addr.push_back(8'h38 + k);
    start_slot(0, 5'd7);
    push_rec(0, 5'd7);
    wait_done(0, "abort restart");
    compare_stream("abort", 1, -1);

    // No sync byte, slot 31: done one cycle earlier.
    rmode[1] = 0;
    start_slot(1, 5'd31);
    push_rec(1, 5'd31);
    wait_done(1, "slot31");
    compare_stream("slot31", 1, 19);

    // read_slot moves and slot_valid drops mid-record: the latched slot completes, then IDLE.
    rmode[0] = 1;
    s = 5'($urandom_range(0, 31));
    slot_valid[0] = 1'b1;
    read_slot[0]  = s;
    c0 = cyc;
    push_rec(0, s);
    repeat (3) tick();
    read_slot[0] = s ^ 5'd5;
    repeat (3) tick();
    slot_valid[0] = 1'b0;
    wait_done(0, "midchange");
    repeat (10) tick();
    check_eq("midchange stays idle", int'(busy[0]), 0);
    compare_stream("midchange", 1, -1);

    // Random slots, contents and ready patterns on both variants.
    for (int n = 0; n < 8; n++) begin
      inst = $urandom_range(0, 1);
      mode = $urandom_range(0, 2);
      s = 5'($urandom);
      for (int k = 0; k < REC_BYTES; k++) mem[{s, 3'(k)}] = 8'($urandom);
      rmode[inst] = mode;
      start_slot(inst, s);
      push_rec(inst, s);
      wait_done(inst, "random");
      compare_stream("random", 1, (mode == 0) ? ((inst == 0) ? 20 : 19) : -1);
      repeat (2) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
